gerador_tom: RTL

GERADOR_TOM -- requirements
Module: gerador_tom

---
 rtl/notas_pkg.sv | 24 ++
 rtl/divisor_tom.sv | 35 +++
 rtl/gerador_tom.sv | 108 ++++++++++
 3 files changed

// File: rtl/notas_pkg.sv
// Shared definitions for the tone generator: note table, half-period helper
// and FSM state encoding.
package notas_pkg;

  localparam int unsigned NUM_NOTAS = 13;

  // Note frequencies in centi-Hz, C4 (index 0) through C5 (index 12).
  localparam int unsigned FREQ_CHZ [NUM_NOTAS] = '{
    26163, 27718, 29366, 31113, 32963, 34923, 36999,
    39200, 41530, 44000, 46616, 49388, 52325
  };

  typedef enum logic {
    SILENCIO = 1'b0,
    TOCANDO  = 1'b1
  } estado_t;

  // Clock cycles per half period of note idx; 64-bit so CLOCK_FREQ*50 cannot overflow.
  function automatic longint unsigned half_count(input longint unsigned clock_freq,
                                                 input int unsigned      idx);
    return (clock_freq * 64'd50) / 64'(FREQ_CHZ[idx]);
  endfunction

endpackage

// File: rtl/divisor_tom.sv
// Loadable half-period counter for the tone generator.
// Ports:
//   clock      - rising-edge clock
//   reset      - synchronous active-low reset
//   carregar   - clears the count (note load, silence)
//   conta      - advance the count; wraps to 0 after reaching limite
//   limite     - terminal value (half-period count minus one)
//   terminal_c - combinational: count equals limite
module divisor_tom #(
  parameter int unsigned CW = 17
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          carregar,
  input  logic          conta,
  input  logic [CW-1:0] limite,
  output logic          terminal_c
);

  logic [CW-1:0] cnt;

  assign terminal_c = (cnt == limite);

  // Clear has priority over counting so a new note always starts from zero.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt <= '0;
    end else if (carregar) begin
      cnt <= '0;
    end else if (conta) begin
      cnt <= terminal_c ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/gerador_tom.sv
// Square-wave tone generator for a buzzer, driven by a one-hot note select.
// Ports:
//   clock       - rising-edge clock
//   reset       - synchronous active-low reset
//   nota        - one-hot note select, bit0=C4 .. bit12=C5, zero = silence
//   habilita    - tone enable; 0 forces silence
//   saida       - registered 50% duty square wave
//   tocando     - registered; high while a valid note is generated
//   fim_periodo - registered one-cycle pulse after each completed period
module gerador_tom
  import notas_pkg::*;
#(
  parameter int unsigned CLOCK_FREQ = 50_000_000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_NOTAS-1:0] nota,
  input  logic                 habilita,
  output logic                 saida,
  output logic                 tocando,
  output logic                 fim_periodo
);

  localparam longint unsigned HALF_C4 = half_count(64'(CLOCK_FREQ), 0);
  localparam longint unsigned HALF_C5 = half_count(64'(CLOCK_FREQ), NUM_NOTAS - 1);
  localparam int unsigned     CW      = $clog2(HALF_C4 + 64'd1);

  if (HALF_C5 < 64'd2) begin : g_erro_half
    $error("gerador_tom: CLOCK_FREQ too low, half period of C5 below 2 cycles");
  end

  estado_t              estado;
  logic [NUM_NOTAS-1:0] r_nota;
  logic [CW-1:0]        limites [NUM_NOTAS];
  logic [CW-1:0]        limite_c;
  logic                 valido_c;
  logic                 diferente_c;
  logic                 conta_c;
  logic                 carregar_c;
  logic                 terminal_c;

  // Per-note terminal counts, all fixed at elaboration.
  for (genvar g = 0; g < NUM_NOTAS; g++) begin : g_lim
    localparam longint unsigned H = half_count(64'(CLOCK_FREQ), g);
    assign limites[g] = CW'(H - 64'd1);
  end

  // r_nota is one-hot whenever it is used, so an OR-select picks one entry.
  always_comb begin
    limite_c = '0;
    for (int i = 0; i < NUM_NOTAS; i++) begin
      if (r_nota[i]) limite_c = limite_c | limites[i];
    end
  end

  assign valido_c    = habilita && $onehot(nota);
  assign diferente_c = (nota != r_nota);
  // Count only while steadily playing the same note; every other case restarts at 0.
  assign conta_c     = (estado == TOCANDO) && valido_c && !diferente_c;
  assign carregar_c  = !conta_c;

  divisor_tom #(.CW(CW)) u_divisor (
    .clock      (clock),
    .reset      (reset),
    .carregar   (carregar_c),
    .conta      (conta_c),
    .limite     (limite_c),
    .terminal_c (terminal_c)
  );

  // Note FSM with registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      estado      <= SILENCIO;
      r_nota      <= '0;
      saida       <= 1'b0;
      tocando     <= 1'b0;
      fim_periodo <= 1'b0;
    end else begin
      fim_periodo <= 1'b0;
      case (estado)
        SILENCIO: begin
          if (valido_c) begin
            estado  <= TOCANDO;
            r_nota  <= nota;
            saida   <= 1'b0;
            tocando <= 1'b1;
          end
        end
        TOCANDO: begin
          if (!valido_c) begin
            estado  <= SILENCIO;
            saida   <= 1'b0;
            tocando <= 1'b0;
          end else if (diferente_c) begin
            // New note restarts cleanly from a low half-period.
            r_nota <= nota;
            saida  <= 1'b0;
          end else if (terminal_c) begin
            saida       <= ~saida;
            fim_periodo <= saida;
          end
        end
      endcase
    end
  end

endmodule
